// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set-2 receiver: synchronises and filters the raw clock/data pair,
// deserialises 11-bit frames and folds E0/F0/E1 prefixes into an 11-bit key event word.
module ps2_key_decoder #(
    parameter int          FILTER_LEN = 8,
    parameter logic [15:0] TIMEOUT    = 16'd6000
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Index 0 carries ps2_clk, index 1 carries ps2_data.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         filt_q, filt_d;
    logic [1:0][FW-1:0] fcnt_q, fcnt_d;
    logic               clk_prev_q;
    logic               fall_s, data_s, tmo_hit_s;

    state_t      state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_ok_q, par_ok_d;
    logic [15:0] timer_q, timer_d;
    logic        byte_valid_q, byte_valid_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;

    logic [10:0] key_q, key_d;
    logic        strobe_q, strobe_d;
    logic        ext_q, ext_d;
    logic        rel_q, rel_d;
    logic [2:0]  skip_q, skip_d;

    assign fall_s    = clk_prev_q & ~filt_q[0];
    assign data_s    = filt_q[1];
    assign tmo_hit_s = (timer_q == (TIMEOUT - 16'd1));

    // Glitch filter: a line's filtered level follows only a persistent disagreement.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                    fcnt_d[i] = '0;
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FW'(1);
                end
            end else begin
                fcnt_d[i] = '0;
            end
        end
    end

    // Frame FSM next-state, shift register, parity and inter-edge timeout.
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;
        tmo_d        = 1'b0;
        if (state_q == S_IDLE || fall_s) begin
            timer_d = 16'd0;
        end else begin
            timer_d = timer_q + 16'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (fall_s) begin
                    if (!data_s) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (fall_s) begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (fall_s) begin
                    par_ok_d = odd_parity_ok(shift_q, data_s);
                    state_d  = S_STOP;
                end else if (tmo_hit_s) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (fall_s) begin
                    state_d = S_IDLE;
                    if (data_s && par_ok_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte decoder: prefix tracking, Pause-sequence swallowing and key event generation.
    always_comb begin
        key_d    = key_q;
        strobe_d = 1'b0;
        ext_d    = ext_q;
        rel_d    = rel_q;
        skip_d   = skip_q;
        if (err_q) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
            if (tmo_q) begin
                skip_d = 3'd0;
            end else begin
                skip_d = skip_q;
            end
        end else if (byte_valid_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (shift_q)
                    8'hE1: skip_d = 3'd7;
                    8'hE0: ext_d  = 1'b1;
                    8'hF0: rel_d  = 1'b1;
                    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                    default: begin
                        key_d    = {~key_q[10], ~rel_q, ext_q, shift_q};
                        strobe_d = 1'b1;
                        ext_d    = 1'b0;
                        rel_d    = 1'b0;
                    end
                endcase
            end
        end else begin
            key_d = key_q;
        end
    end

    // All state registers; lines idle high so synchronisers and filters reset to 1.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            filt_q       <= 2'b11;
            fcnt_q       <= '0;
            clk_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            bitcnt_q     <= 3'd0;
            shift_q      <= 8'd0;
            par_ok_q     <= 1'b0;
            timer_q      <= 16'd0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= 1'b0;
            key_q        <= 11'd0;
            strobe_q     <= 1'b0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            skip_q       <= 3'd0;
        end else begin
            sync1_q      <= {ps2_data_in, ps2_clk_in};
            sync2_q      <= sync1_q;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            clk_prev_q   <= filt_q[0];
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            timer_q      <= timer_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            key_q        <= key_d;
            strobe_q     <= strobe_d;
            ext_q        <= ext_d;
            rel_q        <= rel_d;
            skip_q       <= skip_d;
        end
    end

    assign ps2_key    = key_q;
    assign key_strobe = strobe_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames queue their expected
// events, an independent monitor pops and checks every strobe / error pulse.
module tb_ps2_key_decoder;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic        ps2_clk_in  = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        key_strobe;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_err;
        logic [10:0] key;
    } exp_t;

    exp_t exp_q[$];

    ps2_key_decoder dut (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_key    (ps2_key),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic expect_key(input logic [10:0] k);
        exp_q.push_back({1'b0, k});
    endtask

    task automatic expect_err();
        exp_q.push_back({1'b1, 11'h000});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    // Device drives data while the clock is high, then pulls the clock low.
    task automatic ps2_bit(input logic b);
        ps2_data_in = b;
        wait_cyc(20);
        ps2_clk_in = 1'b0;
        wait_cyc(20);
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data_in = 1'b1;
        wait_cyc(30);
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk_sys) begin
        exp_t e;
        if (!RESET && (key_strobe || frame_err)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output actual strobe=%0b err=%0b key=%h required none",
                         key_strobe, frame_err, ps2_key);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err) begin
                    if (!frame_err || key_strobe) begin
                        bad++;
                        $display("FAIL err_event actual strobe=%0b err=%0b required err only",
                                 key_strobe, frame_err);
                    end
                end else if (!key_strobe || frame_err || ps2_key !== e.key) begin
                    bad++;
                    $display("FAIL key_event actual strobe=%0b err=%0b key=%h required key=%h",
                             key_strobe, frame_err, ps2_key, e.key);
                end
            end
        end
    end

    initial begin
        wait_cyc(4);
        @(negedge clk_sys);
        check("reset_key", ps2_key, 11'h000);
        check("reset_strobe", {10'd0, key_strobe}, 11'h000);
        check("reset_err", {10'd0, frame_err}, 11'h000);
        RESET = 1'b0;
        wait_cyc(20);

        expect_key(11'h61C);
        send_frame(8'h1C, 1'b0);

        expect_key(11'h01C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);

        expect_key(11'h775);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        expect_key(11'h175);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);

        expect_err();
        send_frame(8'h29, 1'b1);
        check("key_held_after_parity_err", ps2_key, 11'h175);
        expect_key(11'h629);
        send_frame(8'h29, 1'b0);

        // Truncated frame: start + 5 data bits, then silence past the timeout.
        expect_err();
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        ps2_data_in = 1'b1;
        wait_cyc(6100);
        check("key_held_after_timeout", ps2_key, 11'h629);
        expect_key(11'h205);
        send_frame(8'h05, 1'b0);

        // Pause sequence is swallowed entirely.
        send_frame(8'hE1, 1'b0);
        send_frame(8'h14, 1'b0);
        send_frame(8'h77, 1'b0);
        send_frame(8'hE1, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h14, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h77, 1'b0);
        check("key_held_after_pause", ps2_key, 11'h205);

        // Short clock glitches with data high would be start errors if sampled.
        for (int g = 0; g < 3; g++) begin
            ps2_clk_in = 1'b0;
            wait_cyc(7);
            ps2_clk_in = 1'b1;
            wait_cyc(20);
        end

        expect_key(11'h56B);
        send_frame(8'hF0, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);

        send_frame(8'hAA, 1'b0);
        check("key_held_after_discard", ps2_key, 11'h56B);

        // Reset in the middle of a frame.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        RESET = 1'b1;
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        wait_cyc(5);
        @(negedge clk_sys);
        check("midreset_key", ps2_key, 11'h000);
        check("midreset_strobe", {10'd0, key_strobe}, 11'h000);
        check("midreset_err", {10'd0, frame_err}, 11'h000);
        RESET = 1'b0;
        wait_cyc(30);

        expect_key(11'h61C);
        send_frame(8'h1C, 1'b0);

        wait_cyc(50);
        check("pending_expectations", 11'(exp_q.size()), 11'h000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Generates the 11-bit ps2_key event word consumed by the emu keyboard logic: {toggle, pressed, extended, code[7:0]}.
- Input is the raw PS/2 keyboard clock/data pair. The block deserialises scan-code set-2 frames and strips the E0/F0/E1 prefixes.
- Sits between the physical PS/2 pins (or an HPS-side passthrough) and the core's keyboard consumer, in the clk_sys domain.

Parameters:
- FILTER_LEN, 8: consecutive clk_sys cycles a synchronised PS/2 line must hold a new level before the filtered level changes.
- TIMEOUT, 16'd6000: clk_sys cycles allowed between filtered ps2_clk falling edges inside a frame before the frame is aborted.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- ps2_clk_in  in  1  raw PS/2 clock, asynchronous.
- ps2_data_in  in  1  raw PS/2 data, asynchronous.
- ps2_key  out  11  [10] toggles per event; [9] 1=make, 0=break; [8] E0-extended; [7:0] scan code.
- key_strobe  out  1  one-cycle pulse in the same cycle ps2_key updates.
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.

Behaviour:
- Reset values (async, RESET=1): ps2_key=0, key_strobe=0, frame_err=0, FSM=IDLE, ext=0, rel=0, skip=0, filtered lines=1, synchronisers=1.
- Input path: 2-flop synchroniser per line, then a glitch filter. The filtered level flips only after the synchronised level differs from it for FILTER_LEN consecutive cycles; any agreeing cycle clears the count.
- Sampling: data is sampled on the cycle a filtered ps2_clk falling edge is detected (filtered 1 to 0).
- Frame FSM:
  - IDLE: on a falling edge, sampled data 0 moves to DATA with bitcnt=0. Sampled data 1 is a start error: pulse frame_err, stay in IDLE.
  - DATA: shift 8 bits, LSB first. After bit 7 go to PARITY.
  - PARITY: check odd parity over data plus parity bit. Latch the result, go to STOP.
  - STOP: stop bit must be 1 and parity must be good. Then byte_valid pulses for one cycle. Otherwise pulse frame_err. Both paths return to IDLE.
- Timeout: in DATA/PARITY/STOP, a timer is cleared on each falling edge. Reaching TIMEOUT pulses frame_err and returns to IDLE; ext, rel and skip are cleared.
- Any frame_err clears ext and rel.
- Byte decode, one cycle after byte_valid:
  - skip!=0: decrement skip; no event.
  - 0xE1: skip=7 (Pause sequence swallowed); no event.
  - 0xE0: ext=1.
  - 0xF0: rel=1.
  - 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF: discarded; clear ext and rel; no event.
  - Any other byte: ps2_key <= {~ps2_key[10], ~rel, ext, byte}; key_strobe=1; clear ext and rel.
- Latency: ps2_key and key_strobe are registered 2 clk_sys cycles after the cycle the stop-bit falling edge is detected.
- Prefix order: E0 F0 xx and F0 E0 xx both yield ext=1, rel=1.
- Simultaneous events: a timeout and a falling edge in the same cycle resolve as the edge (the timer is not yet expired).
- Back-to-back frames with no idle gap are accepted. ps2_key holds its value between events.
- RESET asserted mid-frame aborts immediately. No strobe, no error pulse. ps2_key returns to 0.

Test Plan:
- Frame 0x1C (A), odd parity bit 0, stop 1 -> key_strobe once; ps2_key=11'h61C (toggle 1, make).
- Sequence F0,1C after the above -> single strobe; ps2_key=11'h01C (toggle 0, break).
- Sequence E0,75 then E0,F0,75 -> ps2_key=11'h775, then 11'h175. Exactly two strobes.
- Frame 0x29 with wrong parity -> frame_err one cycle; no strobe; ps2_key unchanged. A following good 0x29 -> ps2_key=11'h629 (assuming the toggle was 0).
- Stop after 5 data bits, idle TIMEOUT+1 cycles -> frame_err pulse at TIMEOUT. A subsequent full 0x05 frame -> ps2_key[7:0]=8'h05, strobe.
- E1 14 77 E1 F0 14 F0 77 -> no strobe, no error. Glitch pulses of FILTER_LEN-1 cycles on ps2_clk_in produce no sampled bits. RESET mid-frame -> all outputs 0.
